// File: rtl/adder_pkg.sv
// Shared widths, operand/sum types and the full-adder carry helper for the CLA-vs-CRA comparison block.
package adder_pkg;
    localparam int WIDTH = 8;
    localparam int SUM_W = WIDTH + 1;
    localparam int GRP_W = 4;

    typedef logic [WIDTH-1:0] operand_t;
    typedef logic [SUM_W-1:0] sum_t;

    function automatic logic fa_carry(input logic g, input logic p, input logic c);
        return g | (p & c);
    endfunction
endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead block: sum bits plus group generate/propagate for the next lookahead level.
// Purely combinational; no state, no backpressure.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       g_grp,
    output logic       p_grp
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened from cin, so no carry depends on a lower carry.
    always_comb begin
        c    = '0;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    end

    assign sum   = p ^ c;
    assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign p_grp = &p;
endmodule

// File: rtl/adder_compare_top.sv
// Two-stage pipeline adding A+B with a CLA and a ripple adder and registering their equality; result 2 edges after input.
// No handshake or stalls; ADDER_FAULT_INJECT_EN adds fault_i, which flips CLA sum bit 0 to exercise the mismatch path.
module adder_compare_top #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef ADDER_FAULT_INJECT_EN
    input  logic             fault_i,
`endif
    output logic             compare,
    output logic             valid,
    output logic [WIDTH:0]   sum
);
    import adder_pkg::*;

    localparam int NGRP = WIDTH / GRP_W;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             v1_q;
    logic             fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
        end else begin
            a_q  <= A;
            b_q  <= B;
            v1_q <= 1'b1;
        end
    end

`ifdef ADDER_FAULT_INJECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_i;
        end
    end
`else
    assign fault_q = 1'b0;
`endif

    // Carry-lookahead adder: 4-bit groups chained through their group G/P.
    logic [NGRP:0]    gc;
    logic [NGRP-1:0]  gg;
    logic [NGRP-1:0]  gp;
    logic [WIDTH-1:0] cla_bits;
    logic [WIDTH:0]   sum_cla;

    assign gc[0] = 1'b0;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_cla
        cla4 u_cla4 (
            .a     (a_q[gi*GRP_W +: GRP_W]),
            .b     (b_q[gi*GRP_W +: GRP_W]),
            .cin   (gc[gi]),
            .sum   (cla_bits[gi*GRP_W +: GRP_W]),
            .g_grp (gg[gi]),
            .p_grp (gp[gi])
        );
        assign gc[gi+1] = gg[gi] | (gp[gi] & gc[gi]);
    end

    assign sum_cla = {gc[NGRP], cla_bits};

    // Carry-ripple adder: one full adder per bit.
    logic [WIDTH:0]   rc;
    logic [WIDTH-1:0] cra_bits;
    logic [WIDTH:0]   sum_cra;

    always_comb begin
        rc       = '0;
        cra_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cra_bits[i] = a_q[i] ^ b_q[i] ^ rc[i];
            rc[i+1]     = fa_carry(a_q[i] & b_q[i], a_q[i] ^ b_q[i], rc[i]);
        end
    end

    assign sum_cra = {rc[WIDTH], cra_bits};

    logic [WIDTH:0] sum_chk;
    assign sum_chk = sum_cla ^ {{WIDTH{1'b0}}, fault_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            compare <= 1'b0;
            valid   <= 1'b0;
        end else begin
            sum     <= sum_chk;
            compare <= (sum_chk == sum_cra);
            valid   <= v1_q;
        end
    end
endmodule

// File: tb/tb_adder_compare_top.sv
// Bench for adder_compare_top: table vectors, reset/latency corners, random pairs and a full operand sweep.
module tb_adder_compare_top;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       fault_i = 1'b0;
    logic       compare;
    logic       valid;
    logic [8:0] sum;

    adder_compare_top #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
`ifdef ADDER_FAULT_INJECT_EN
        .fault_i (fault_i),
`endif
        .compare (compare),
        .valid   (valid),
        .sum     (sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int exp_sum;
    } vec_t;

    typedef struct {
        int a;
        int b;
        int exp_sum;
        bit exp_cmp;
    } pend_t;

    int    errors = 0;
    int    checks = 0;
    pend_t pipe[$];
    vec_t  vecs[8];

    task automatic chk(input string name, input logic [15:0] act, input int exp);
        checks++;
        if (act !== exp[15:0]) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one pair, advance one edge, then check whatever result is due two edges after its input.
    task automatic step(input int a, input int b, input bit f, input int es, input bit ec);
        pend_t e;
        A       = a[7:0];
        B       = b[7:0];
        fault_i = f;
        pipe.push_back('{a, b, es, ec});
        @(posedge clk);
        #1;
        if (pipe.size() >= 2) begin
            e = pipe.pop_front();
            chk($sformatf("valid %0d+%0d", e.a, e.b), {15'd0, valid}, 1);
            chk($sformatf("sum %0d+%0d", e.a, e.b), {7'd0, sum}, e.exp_sum);
            chk($sformatf("compare %0d+%0d", e.a, e.b), {15'd0, compare}, int'(e.exp_cmp));
        end else begin
            chk("valid_latency", {15'd0, valid}, 0);
        end
    endtask

    initial begin
        vecs[0] = '{255, 122, 377};
        vecs[1] = '{12, 124, 136};
        vecs[2] = '{3, 10, 13};
        vecs[3] = '{200, 30, 230};
        vecs[4] = '{23, 100, 123};
        vecs[5] = '{255, 255, 510};
        vecs[6] = '{255, 1, 256};
        vecs[7] = '{0, 0, 0};

        // Reset held with zero operands.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {15'd0, valid}, 0);
        chk("reset_compare", {15'd0, compare}, 0);
        chk("reset_sum", {7'd0, sum}, 0);
        rst_n = 1'b1;
        pipe.delete();
        step(0, 0, 1'b0, 0, 1'b1);
        step(0, 0, 1'b0, 0, 1'b1);

        foreach (vecs[i]) step(vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp_sum, 1'b1);

        // Async reset between edges while 200/30 sits in stage 1.
        step(200, 30, 1'b0, 230, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {15'd0, valid}, 0);
        chk("async_sum", {7'd0, sum}, 0);
        chk("async_compare", {15'd0, compare}, 0);
        pipe.delete();
        @(posedge clk);
        #1;
        chk("async_no_230", {7'd0, sum}, 0);
        chk("async_valid_held", {15'd0, valid}, 0);
        #2;
        rst_n = 1'b1;
        step(23, 100, 1'b0, 123, 1'b1);
        step(255, 1, 1'b0, 256, 1'b1);

`ifdef ADDER_FAULT_INJECT_EN
        step(12, 124, 1'b1, 137, 1'b0);
        step(3, 10, 1'b0, 13, 1'b1);
        step(255, 255, 1'b0, 510, 1'b1);
`endif

        for (int i = 0; i < 300; i++) begin
            int a;
            int b;
            a = int'($urandom_range(255, 0));
            b = int'($urandom_range(255, 0));
            step(a, b, 1'b0, a + b, 1'b1);
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                step(a, b, 1'b0, a + b, 1'b1);
            end
        end
        step(0, 0, 1'b0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
